lsu_align_unit: RTL and testbench

- Parametrised load/store alignment engine for the multicycle RISC-V core, between the datapath and a word-wide data memory port.
- Generalises the combinational store-size decoder:
  - XLEN of 32 or 64.
  - Generates byte enables and applies byte-lane shifting.
  - Zero- or sign-extends loads.
  - Optionally splits misaligned accesses into two bus transactions through a small handshake FSM.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_extend.sv | 33 +++
 rtl/lsu_align_unit.sv | 165 ++++++++++++++++
 tb/tb_lsu_align_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store alignment engine: funct3 encodings,
// access size, FSM state, and the size-to-byte-count helper.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, RESP, FAULT_RESP} state_t;

    function automatic logic [3:0] size_bytes(input size_t s);
        case (s)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Extracts a load value from a two-word read buffer at a byte offset and
// sign- or zero-extends it to XLEN. Purely combinational.
module lsu_extend
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OB  = $clog2(XLEN / 8)
) (
    input  logic [2*XLEN-1:0] data_buf,
    input  logic [OB-1:0]     off,
    input  size_t             size,
    input  logic              uns,
    output logic [XLEN-1:0]   result
);

    logic [XLEN-1:0] low;
    logic [XLEN-1:0] mask;
    logic            sign;

    always_comb begin
        low  = XLEN'(data_buf >> {off, 3'b000});
        mask = '1;
        sign = low[XLEN-1];
        case (size)
            SZ_B: begin mask = XLEN'(8'hFF);         sign = low[7];  end
            SZ_H: begin mask = XLEN'(16'hFFFF);      sign = low[15]; end
            SZ_W: begin mask = XLEN'(32'hFFFF_FFFF); sign = low[31]; end
            default: begin mask = '1; sign = low[XLEN-1]; end
        endcase
        result = (low & mask) | ((sign && !uns) ? ~mask : '0);
    end

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store alignment engine: byte enables, lane shifting, load extension,
// and optional two-transaction splitting of word-crossing accesses.
module lsu_align_unit
    import lsu_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1,
    localparam int NB  = XLEN / 8,
    localparam int OB  = $clog2(NB),
    localparam int NB2 = 2 * NB
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [NB-1:0]   mem_be,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault
);

    state_t             state;
    logic [OB-1:0]      off_q;
    size_t              size_q;
    logic               uns_q;
    logic               store_q;
    logic               cross_q;
    logic [NB-1:0]      be_hi_q;
    logic [XLEN-1:0]    wdata_hi_q;
    logic [2*XLEN-1:0]  buf_q;

    size_t              req_size;
    logic [OB-1:0]      req_off;
    logic [3:0]         req_bytes;
    logic               req_cross;
    logic               req_illegal;
    logic [NB2-1:0]     mask_wide;
    logic [2*XLEN-1:0]  wdata_wide;
    logic [2*XLEN-1:0]  buf_next;
    logic [XLEN-1:0]    ext_result;

    always_comb begin
        req_size    = size_t'(req_funct3[1:0]);
        req_off     = req_addr[OB-1:0];
        req_bytes   = size_bytes(req_size);
        req_cross   = (5'(req_off) + 5'(req_bytes)) > 5'(NB);
        req_illegal = (req_funct3 == 3'b111)
                    || ((XLEN == 32) && (req_funct3[1:0] == 2'b11))
                    || ((XLEN == 32) && (req_funct3 == LWU))
                    || (req_store && req_funct3[2]);
        // The upper halves of these wide shifts are exactly the second-beat lanes.
        mask_wide   = NB2'((16'd1 << req_bytes) - 16'd1) << req_off;
        wdata_wide  = {{XLEN{1'b0}}, req_wdata} << {req_off, 3'b000};
        buf_next    = (state == ACC1) ? {mem_rdata, buf_q[XLEN-1:0]}
                                      : {buf_q[2*XLEN-1:XLEN], mem_rdata};
    end

    // Extension works on the buffer as it will look after this beat, so the
    // response can be registered on the same edge as the final bus beat.
    lsu_extend #(.XLEN(XLEN)) u_extend (
        .data_buf (buf_next),
        .off      (off_q),
        .size     (size_q),
        .uns      (uns_q),
        .result   (ext_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
            off_q      <= '0;
            size_q     <= SZ_B;
            uns_q      <= 1'b0;
            store_q    <= 1'b0;
            cross_q    <= 1'b0;
            be_hi_q    <= '0;
            wdata_hi_q <= '0;
            buf_q      <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req_ready  <= 1'b0;
                    off_q      <= req_off;
                    size_q     <= req_size;
                    uns_q      <= req_funct3[2];
                    store_q    <= req_store;
                    cross_q    <= req_cross;
                    be_hi_q    <= mask_wide[NB2-1:NB];
                    wdata_hi_q <= wdata_wide[2*XLEN-1:XLEN];
                    if (req_illegal || (req_cross && !SPLIT_MISALIGNED)) begin
                        state      <= FAULT_RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        state     <= ACC0;
                        mem_valid <= 1'b1;
                        mem_we    <= req_store;
                        mem_addr  <= {req_addr[XLEN-1:OB], {OB{1'b0}}};
                        mem_be    <= mask_wide[NB-1:0];
                        mem_wdata <= wdata_wide[XLEN-1:0];
                    end
                end
                ACC0: if (mem_ready) begin
                    buf_q[XLEN-1:0] <= mem_rdata;
                    if (cross_q) begin
                        state     <= ACC1;
                        mem_addr  <= mem_addr + XLEN'(NB);
                        mem_be    <= be_hi_q;
                        mem_wdata <= wdata_hi_q;
                    end else begin
                        state      <= RESP;
                        mem_valid  <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_be     <= '0;
                        mem_wdata  <= '0;
                        resp_valid <= 1'b1;
                        resp_rdata <= store_q ? '0 : ext_result;
                    end
                end
                ACC1: if (mem_ready) begin
                    buf_q[2*XLEN-1:XLEN] <= mem_rdata;
                    state      <= RESP;
                    mem_valid  <= 1'b0;
                    mem_we     <= 1'b0;
                    mem_be     <= '0;
                    mem_wdata  <= '0;
                    resp_valid <= 1'b1;
                    resp_rdata <= store_q ? '0 : ext_result;
                end
                RESP, FAULT_RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    resp_rdata <= '0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Directed bench for lsu_align_unit: 32-bit split, 32-bit fault-on-misalign
// and 64-bit split instances sharing one clock and reset.
module tb_lsu_align_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic        a_req_valid, a_req_ready, a_req_store, a_mem_valid, a_mem_ready, a_mem_we;
    logic        a_resp_valid, a_resp_fault;
    logic [2:0]  a_req_funct3;
    logic [31:0] a_req_addr, a_req_wdata, a_mem_addr, a_mem_wdata, a_mem_rdata, a_resp_rdata;
    logic [3:0]  a_mem_be;

    logic        n_req_valid, n_req_ready, n_req_store, n_mem_valid, n_mem_ready, n_mem_we;
    logic        n_resp_valid, n_resp_fault;
    logic [2:0]  n_req_funct3;
    logic [31:0] n_req_addr, n_req_wdata, n_mem_addr, n_mem_wdata, n_mem_rdata, n_resp_rdata;
    logic [3:0]  n_mem_be;

    logic        w_req_valid, w_req_ready, w_req_store, w_mem_valid, w_mem_ready, w_mem_we;
    logic        w_resp_valid, w_resp_fault;
    logic [2:0]  w_req_funct3;
    logic [63:0] w_req_addr, w_req_wdata, w_mem_addr, w_mem_wdata, w_mem_rdata, w_resp_rdata;
    logic [7:0]  w_mem_be;

    lsu_align_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_store(a_req_store),
        .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .mem_valid(a_mem_valid), .mem_ready(a_mem_ready), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_be(a_mem_be),
        .mem_rdata(a_mem_rdata), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
        .resp_fault(a_resp_fault));

    lsu_align_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b0)) dut_n (
        .clk(clk), .reset(reset),
        .req_valid(n_req_valid), .req_ready(n_req_ready), .req_store(n_req_store),
        .req_funct3(n_req_funct3), .req_addr(n_req_addr), .req_wdata(n_req_wdata),
        .mem_valid(n_mem_valid), .mem_ready(n_mem_ready), .mem_we(n_mem_we),
        .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata), .mem_be(n_mem_be),
        .mem_rdata(n_mem_rdata), .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata),
        .resp_fault(n_resp_fault));

    lsu_align_unit #(.XLEN(64), .SPLIT_MISALIGNED(1'b1)) dut_w (
        .clk(clk), .reset(reset),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_store(w_req_store),
        .req_funct3(w_req_funct3), .req_addr(w_req_addr), .req_wdata(w_req_wdata),
        .mem_valid(w_mem_valid), .mem_ready(w_mem_ready), .mem_we(w_mem_we),
        .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_be(w_mem_be),
        .mem_rdata(w_mem_rdata), .resp_valid(w_resp_valid), .resp_rdata(w_resp_rdata),
        .resp_fault(w_resp_fault));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_req(input logic st, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        a_req_valid = 1'b1; a_req_store = st; a_req_funct3 = f3; a_req_addr = addr; a_req_wdata = wd;
    endtask

    task automatic n_req(input logic st, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        n_req_valid = 1'b1; n_req_store = st; n_req_funct3 = f3; n_req_addr = addr; n_req_wdata = wd;
    endtask

    task automatic w_req(input logic st, input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wd);
        w_req_valid = 1'b1; w_req_store = st; w_req_funct3 = f3; w_req_addr = addr; w_req_wdata = wd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        total++; if (a_req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", a_req_ready); else passed++;
        total++; if (a_mem_valid !== 1'b0) $display("FAIL reset_mem_valid: got %b want 0", a_mem_valid); else passed++;
        total++; if (a_resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", a_resp_valid); else passed++;
        total++; if (w_req_ready !== 1'b1) $display("FAIL reset_ready64: got %b want 1", w_req_ready); else passed++;
    endtask

    task automatic test_load_byte();
        a_req(1'b0, LB, 32'h1003, 32'h0);
        tick();
        a_req_valid = 1'b0;
        total++; if (a_mem_valid !== 1'b1) $display("FAIL lb_mem_valid: got %b want 1", a_mem_valid); else passed++;
        total++; if (a_mem_addr !== 32'h1000) $display("FAIL lb_addr: got %h want 00001000", a_mem_addr); else passed++;
        total++; if (a_mem_be !== 4'b1000) $display("FAIL lb_be: got %b want 1000", a_mem_be); else passed++;
        total++; if (a_mem_we !== 1'b0) $display("FAIL lb_we: got %b want 0", a_mem_we); else passed++;
        a_mem_rdata = 32'h80AABBCC;
        tick();
        total++; if (a_resp_valid !== 1'b1) $display("FAIL lb_resp_valid: got %b want 1", a_resp_valid); else passed++;
        total++; if (a_resp_rdata !== 32'hFFFFFF80) $display("FAIL lb_rdata: got %h want ffffff80", a_resp_rdata); else passed++;
        total++; if (a_mem_valid !== 1'b0) $display("FAIL lb_mem_drop: got %b want 0", a_mem_valid); else passed++;
        tick();
        total++; if (a_resp_valid !== 1'b0) $display("FAIL lb_resp_pulse: got %b want 0", a_resp_valid); else passed++;
        total++; if (a_req_ready !== 1'b1) $display("FAIL lb_ready_back: got %b want 1", a_req_ready); else passed++;
        a_req(1'b0, LBU, 32'h1003, 32'h0);
        tick();
        a_req_valid = 1'b0;
        tick();
        total++; if (a_resp_rdata !== 32'h00000080) $display("FAIL lbu_rdata: got %h want 00000080", a_resp_rdata); else passed++;
        tick();
    endtask

    task automatic test_store_half();
        a_req(1'b1, SH, 32'h1002, 32'h0000BEEF);
        tick();
        a_req_valid = 1'b0;
        total++; if (a_mem_we !== 1'b1) $display("FAIL sh_we: got %b want 1", a_mem_we); else passed++;
        total++; if (a_mem_be !== 4'b1100) $display("FAIL sh_be: got %b want 1100", a_mem_be); else passed++;
        total++; if (a_mem_wdata !== 32'hBEEF0000) $display("FAIL sh_wdata: got %h want beef0000", a_mem_wdata); else passed++;
        tick();
        total++; if (a_resp_valid !== 1'b1) $display("FAIL sh_resp_valid: got %b want 1", a_resp_valid); else passed++;
        total++; if (a_resp_rdata !== 32'h0) $display("FAIL sh_rdata: got %h want 00000000", a_resp_rdata); else passed++;
        tick();
    endtask

    task automatic test_split_load();
        a_req(1'b0, LW, 32'h1002, 32'h0);
        tick();
        a_req_valid = 1'b0;
        total++; if (a_mem_addr !== 32'h1000) $display("FAIL lwx_addr0: got %h want 00001000", a_mem_addr); else passed++;
        total++; if (a_mem_be !== 4'b1100) $display("FAIL lwx_be0: got %b want 1100", a_mem_be); else passed++;
        a_mem_rdata = 32'hAABBCCDD;
        tick();
        total++; if (a_mem_valid !== 1'b1) $display("FAIL lwx_valid1: got %b want 1", a_mem_valid); else passed++;
        total++; if (a_mem_addr !== 32'h1004) $display("FAIL lwx_addr1: got %h want 00001004", a_mem_addr); else passed++;
        total++; if (a_mem_be !== 4'b0011) $display("FAIL lwx_be1: got %b want 0011", a_mem_be); else passed++;
        total++; if (a_resp_valid !== 1'b0) $display("FAIL lwx_early_resp: got %b want 0", a_resp_valid); else passed++;
        a_mem_rdata = 32'h11223344;
        tick();
        total++; if (a_resp_valid !== 1'b1) $display("FAIL lwx_resp_valid: got %b want 1", a_resp_valid); else passed++;
        total++; if (a_resp_rdata !== 32'h3344AABB) $display("FAIL lwx_rdata: got %h want 3344aabb", a_resp_rdata); else passed++;
        tick();
    endtask

    task automatic test_split_store();
        a_req(1'b1, SW, 32'h0FFE, 32'h11223344);
        tick();
        a_req_valid = 1'b0;
        total++; if (a_mem_addr !== 32'h0FFC) $display("FAIL swx_addr0: got %h want 00000ffc", a_mem_addr); else passed++;
        total++; if (a_mem_be !== 4'b1100) $display("FAIL swx_be0: got %b want 1100", a_mem_be); else passed++;
        total++; if (a_mem_wdata !== 32'h33440000) $display("FAIL swx_wdata0: got %h want 33440000", a_mem_wdata); else passed++;
        tick();
        total++; if (a_mem_addr !== 32'h1000) $display("FAIL swx_addr1: got %h want 00001000", a_mem_addr); else passed++;
        total++; if (a_mem_be !== 4'b0011) $display("FAIL swx_be1: got %b want 0011", a_mem_be); else passed++;
        total++; if (a_mem_wdata !== 32'h00001122) $display("FAIL swx_wdata1: got %h want 00001122", a_mem_wdata); else passed++;
        total++; if (a_mem_we !== 1'b1) $display("FAIL swx_we1: got %b want 1", a_mem_we); else passed++;
        tick();
        total++; if (a_resp_valid !== 1'b1) $display("FAIL swx_resp_valid: got %b want 1", a_resp_valid); else passed++;
        tick();
    endtask

    task automatic test_wait_states();
        a_mem_ready = 1'b0;
        a_req(1'b0, LH, 32'h1000, 32'h0);
        tick();
        a_req(1'b1, SW, 32'h2000, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (a_mem_valid !== 1'b1) $display("FAIL wait_valid[%0d]: got %b want 1", i, a_mem_valid); else passed++;
            total++; if (a_mem_addr !== 32'h1000) $display("FAIL wait_addr[%0d]: got %h want 00001000", i, a_mem_addr); else passed++;
            total++; if (a_mem_be !== 4'b0011) $display("FAIL wait_be[%0d]: got %b want 0011", i, a_mem_be); else passed++;
            total++; if (a_mem_we !== 1'b0) $display("FAIL wait_we[%0d]: got %b want 0", i, a_mem_we); else passed++;
            total++; if (a_req_ready !== 1'b0) $display("FAIL wait_ready[%0d]: got %b want 0", i, a_req_ready); else passed++;
        end
        a_req_valid = 1'b0;
        a_mem_ready = 1'b1;
        a_mem_rdata = 32'h00008001;
        tick();
        total++; if (a_resp_valid !== 1'b1) $display("FAIL wait_resp_valid: got %b want 1", a_resp_valid); else passed++;
        total++; if (a_resp_rdata !== 32'hFFFF8001) $display("FAIL wait_rdata: got %h want ffff8001", a_resp_rdata); else passed++;
        tick();
        total++; if (a_mem_valid !== 1'b0) $display("FAIL wait_ignored_req: got %b want 0", a_mem_valid); else passed++;
    endtask

    task automatic test_reset_mid_access();
        a_req(1'b0, LW, 32'h1003, 32'h0);
        tick();
        a_req_valid = 1'b0;
        tick();
        total++; if (a_mem_addr !== 32'h1004) $display("FAIL rst_acc1_addr: got %h want 00001004", a_mem_addr); else passed++;
        a_mem_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a_mem_ready = 1'b1;
        total++; if (a_mem_valid !== 1'b0) $display("FAIL rst_mem_valid: got %b want 0", a_mem_valid); else passed++;
        total++; if (a_req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", a_req_ready); else passed++;
        for (int i = 0; i < 3; i++) begin
            total++; if (a_resp_valid !== 1'b0) $display("FAIL rst_no_resp[%0d]: got %b want 0", i, a_resp_valid); else passed++;
            tick();
        end
    endtask

    task automatic test_fault();
        a_req(1'b0, 3'b011, 32'h1000, 32'h0);
        tick();
        a_req_valid = 1'b0;
        total++; if (a_resp_valid !== 1'b1) $display("FAIL ld32_resp_valid: got %b want 1", a_resp_valid); else passed++;
        total++; if (a_resp_fault !== 1'b1) $display("FAIL ld32_fault: got %b want 1", a_resp_fault); else passed++;
        total++; if (a_mem_valid !== 1'b0) $display("FAIL ld32_mem_valid: got %b want 0", a_mem_valid); else passed++;
        tick();
        total++; if (a_resp_fault !== 1'b0) $display("FAIL ld32_fault_pulse: got %b want 0", a_resp_fault); else passed++;
        total++; if (a_req_ready !== 1'b1) $display("FAIL ld32_ready_back: got %b want 1", a_req_ready); else passed++;
        a_req(1'b1, 3'b100, 32'h1000, 32'h0);
        tick();
        a_req_valid = 1'b0;
        total++; if (a_resp_fault !== 1'b1) $display("FAIL st_unsigned_fault: got %b want 1", a_resp_fault); else passed++;
        tick();
    endtask

    task automatic test_no_split();
        n_req(1'b0, LW, 32'h1001, 32'h0);
        tick();
        n_req_valid = 1'b0;
        total++; if (n_resp_fault !== 1'b1) $display("FAIL nosplit_fault: got %b want 1", n_resp_fault); else passed++;
        total++; if (n_mem_valid !== 1'b0) $display("FAIL nosplit_mem_valid: got %b want 0", n_mem_valid); else passed++;
        tick();
        n_req(1'b0, LW, 32'h1004, 32'h0);
        tick();
        n_req_valid = 1'b0;
        total++; if (n_mem_be !== 4'b1111) $display("FAIL nosplit_aligned_be: got %b want 1111", n_mem_be); else passed++;
        n_mem_rdata = 32'h12345678;
        tick();
        total++; if (n_resp_rdata !== 32'h12345678) $display("FAIL nosplit_rdata: got %h want 12345678", n_resp_rdata); else passed++;
        total++; if (n_resp_fault !== 1'b0) $display("FAIL nosplit_no_fault: got %b want 0", n_resp_fault); else passed++;
        tick();
    endtask

    task automatic test_xlen64();
        w_req(1'b0, LD, 64'h1004, 64'h0);
        tick();
        w_req_valid = 1'b0;
        total++; if (w_mem_addr !== 64'h1000) $display("FAIL ld64_addr0: got %h want 1000", w_mem_addr); else passed++;
        total++; if (w_mem_be !== 8'b11110000) $display("FAIL ld64_be0: got %b want 11110000", w_mem_be); else passed++;
        w_mem_rdata = 64'h8877665544332211;
        tick();
        total++; if (w_mem_addr !== 64'h1008) $display("FAIL ld64_addr1: got %h want 1008", w_mem_addr); else passed++;
        total++; if (w_mem_be !== 8'b00001111) $display("FAIL ld64_be1: got %b want 00001111", w_mem_be); else passed++;
        w_mem_rdata = 64'h00FFEEDDCCBBAA99;
        tick();
        total++; if (w_resp_valid !== 1'b1) $display("FAIL ld64_resp_valid: got %b want 1", w_resp_valid); else passed++;
        total++; if (w_resp_rdata !== 64'hCCBBAA9988776655) $display("FAIL ld64_rdata: got %h want ccbbaa9988776655", w_resp_rdata); else passed++;
        tick();
        w_req(1'b0, LW, 64'h1000, 64'h0);
        tick();
        w_req_valid = 1'b0;
        total++; if (w_mem_be !== 8'b00001111) $display("FAIL lw64_be: got %b want 00001111", w_mem_be); else passed++;
        w_mem_rdata = 64'h1111111180000000;
        tick();
        total++; if (w_resp_rdata !== 64'hFFFFFFFF80000000) $display("FAIL lw64_rdata: got %h want ffffffff80000000", w_resp_rdata); else passed++;
        tick();
    endtask

    initial begin
        a_req_valid = 1'b0; a_req_store = 1'b0; a_req_funct3 = 3'b0; a_req_addr = '0; a_req_wdata = '0;
        a_mem_ready = 1'b1; a_mem_rdata = '0;
        n_req_valid = 1'b0; n_req_store = 1'b0; n_req_funct3 = 3'b0; n_req_addr = '0; n_req_wdata = '0;
        n_mem_ready = 1'b1; n_mem_rdata = '0;
        w_req_valid = 1'b0; w_req_store = 1'b0; w_req_funct3 = 3'b0; w_req_addr = '0; w_req_wdata = '0;
        w_mem_ready = 1'b1; w_mem_rdata = '0;

        test_reset();
        test_load_byte();
        test_store_half();
        test_split_load();
        test_split_store();
        test_wait_states();
        test_reset_mid_access();
        test_fault();
        test_no_split();
        test_xlen64();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
